// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU, the secondary master and the SRAM pins.
// The arbiter takes the slave view; the surrounding system takes the master view.
interface mem_arbiter_if;
  logic [15:0] cpu_address;
  logic [15:0] cpu_data_out;
  logic        cpu_wren_n;
  logic        cpu_oen_n;
  logic [15:0] cpu_data_in;
  logic        cpu_hold;

  logic        dev_valid;
  logic        dev_we;
  logic [15:0] dev_address;
  logic [15:0] dev_wdata;
  logic        dev_ready;
  logic        dev_rvalid;
  logic [15:0] dev_rdata;

  logic [15:0] mem_address;
  logic [15:0] mem_data_out;
  logic        mem_wren_n;
  logic        mem_oen_n;
  logic [15:0] mem_data_in;

  modport slave (
    input  cpu_address, cpu_data_out, cpu_wren_n, cpu_oen_n,
    output cpu_data_in, cpu_hold,
    input  dev_valid, dev_we, dev_address, dev_wdata,
    output dev_ready, dev_rvalid, dev_rdata,
    output mem_address, mem_data_out, mem_wren_n, mem_oen_n,
    input  mem_data_in
  );

  modport master (
    output cpu_address, cpu_data_out, cpu_wren_n, cpu_oen_n,
    input  cpu_data_in, cpu_hold,
    output dev_valid, dev_we, dev_address, dev_wdata,
    input  dev_ready, dev_rvalid, dev_rdata,
    input  mem_address, mem_data_out, mem_wren_n, mem_oen_n,
    output mem_data_in
  );
endinterface

// File: rtl/mem_arbiter.sv
// SRAM bus arbiter: CPU passes straight through, secondary master uses idle cycles.
// Define MEM_ARB_STARVE_EN to add the starvation counter and the forced HOLD slot.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);

  if (STARVE_LIMIT < 2 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("mem_arbiter: STARVE_LIMIT must be in 2..15");
  end

  logic cpu_busy;
  logic hold_active;
  logic dev_grant;
  logic dev_rvalid_reg;
  logic dev_rvalid_next;

  assign cpu_busy = !bus.cpu_wren_n || !bus.cpu_oen_n;

`ifdef MEM_ARB_STARVE_EN
  typedef enum logic {ARB, HOLD} state_t;

  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
  localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

  state_t     state_reg, state_next;
  logic [3:0] starve_cnt_reg, starve_cnt_next;
  logic       deny;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ARB;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // HOLD lends the bus to the waiting master for exactly one cycle.
  always_comb begin
    hold_active     = !rst && (state_reg == HOLD);
    dev_grant       = !rst && bus.dev_valid && (hold_active || !cpu_busy);
    deny            = bus.dev_valid && !dev_grant;
    state_next      = ARB;
    starve_cnt_next = '0;
    if (deny) begin
      starve_cnt_next = (starve_cnt_reg == LIMIT) ? LIMIT : starve_cnt_reg + 4'd1;
      if (state_reg == ARB && starve_cnt_reg == LIMIT_M1) begin
        state_next = HOLD;
      end
    end
  end
`else
  assign hold_active = 1'b0;
  assign dev_grant   = !rst && bus.dev_valid && !cpu_busy;
`endif

  // Strobes stay high unless exactly one owner is driving; reset parks the bus.
  always_comb begin
    bus.mem_address  = bus.cpu_address;
    bus.mem_data_out = bus.cpu_data_out;
    bus.mem_wren_n   = 1'b1;
    bus.mem_oen_n    = 1'b1;
    if (dev_grant) begin
      bus.mem_address  = bus.dev_address;
      bus.mem_data_out = bus.dev_wdata;
      bus.mem_wren_n   = !bus.dev_we;
      bus.mem_oen_n    = bus.dev_we;
    end else if (!rst && !hold_active) begin
      bus.mem_wren_n = bus.cpu_wren_n;
      bus.mem_oen_n  = bus.cpu_oen_n;
    end
  end

  assign dev_rvalid_next = dev_grant && !bus.dev_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      dev_rvalid_reg <= 1'b0;
    end else begin
      dev_rvalid_reg <= dev_rvalid_next;
    end
  end

  assign bus.dev_ready   = dev_grant;
  assign bus.dev_rvalid  = dev_rvalid_reg;
  assign bus.dev_rdata   = bus.mem_data_in;
  assign bus.cpu_data_in = bus.mem_data_in;
  assign bus.cpu_hold    = hold_active;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, starvation sequences, random run against a model.
// Follows MEM_ARB_STARVE_EN the same way as the design.
module tb_mem_arbiter;
  localparam int LIMIT = 8;
`ifdef MEM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: counts consecutive refusals; reaching LIMIT buys the next cycle.
  int   m_cnt = 0;
  bit   m_hold = 1'b0;
  bit   m_rvalid = 1'b0;
  logic e_ready, e_hold, e_wren, e_oen;
  logic [15:0] e_addr, e_data;

  task automatic model_eval();
    logic busy;
    busy    = !bus.cpu_wren_n || !bus.cpu_oen_n;
    e_hold  = !rst && m_hold;
    e_ready = !rst && bus.dev_valid && (e_hold || !busy);
    e_addr  = e_ready ? bus.dev_address : bus.cpu_address;
    e_data  = e_ready ? bus.dev_wdata : bus.cpu_data_out;
    if (e_ready) begin
      e_wren = !bus.dev_we;
      e_oen  = bus.dev_we;
    end else if (rst || e_hold) begin
      e_wren = 1'b1;
      e_oen  = 1'b1;
    end else begin
      e_wren = bus.cpu_wren_n;
      e_oen  = bus.cpu_oen_n;
    end
  endtask

  task automatic model_advance();
    if (rst) begin
      m_cnt = 0; m_hold = 1'b0; m_rvalid = 1'b0;
    end else begin
      m_rvalid = e_ready && !bus.dev_we;
      if (bus.dev_valid && !e_ready) begin
        m_cnt++;
        m_hold = STARVE_EN && (m_cnt >= LIMIT);
      end else begin
        m_cnt = 0; m_hold = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic        rst;
    logic [15:0] ca, cd;
    logic        cw, co;
    logic        dv, dw;
    logic [15:0] da, dd, md;
    logic        e_ready, e_hold, e_wren, e_oen;
    logic        chk_bus;
    logic [15:0] e_addr, e_data;
    logic        e_rvalid;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic drive(input logic r, input logic [15:0] ca, input logic [15:0] cd,
                       input logic cw, input logic co, input logic dv, input logic dw,
                       input logic [15:0] da, input logic [15:0] dd, input logic [15:0] md);
    rst = r;
    bus.cpu_address = ca; bus.cpu_data_out = cd;
    bus.cpu_wren_n = cw;  bus.cpu_oen_n = co;
    bus.dev_valid = dv;   bus.dev_we = dw;
    bus.dev_address = da; bus.dev_wdata = dd;
    bus.mem_data_in = md;
  endtask

  task automatic run_until_grant(output int denies, output bit granted);
    denies = 0;
    granted = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.dev_ready) begin
        granted = 1'b1;
        break;
      end
      denies++;
      tick();
    end
  endtask

  initial begin
    int d1, d2;
    bit g1, g2;
    int grants, holds;
    bit pend;

    //          rst   ca       cd       cw co  dv dw  da       dd       md        rdy hld wr oe chk addr     data     rv
    vecs[0] = '{1'b1, 16'h1111, 16'h2222, 1, 0, 1, 0, 16'h0040, 16'h0000, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 0};
    vecs[1] = '{1'b1, 16'h1111, 16'h2222, 1, 0, 1, 0, 16'h0040, 16'h0000, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 0};
    vecs[2] = '{1'b0, 16'h1234, 16'hBEEF, 0, 1, 1, 0, 16'h0040, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 16'h1234, 16'hBEEF, 0};
    vecs[3] = '{1'b0, 16'h1234, 16'hBEEF, 1, 1, 1, 0, 16'h0040, 16'h0000, 16'h0000, 1, 0, 1, 0, 1, 16'h0040, 16'h0000, 0};
    vecs[4] = '{1'b0, 16'h1234, 16'hBEEF, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'h5A5A, 0, 0, 1, 1, 1, 16'h1234, 16'hBEEF, 1};
    vecs[5] = '{1'b0, 16'h1234, 16'hBEEF, 1, 1, 1, 1, 16'h0100, 16'h00FF, 16'h0000, 1, 0, 0, 1, 1, 16'h0100, 16'h00FF, 0};
    vecs[6] = '{1'b0, 16'h4444, 16'h5555, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'h1357, 0, 0, 1, 1, 1, 16'h4444, 16'h5555, 0};
    vecs[7] = '{1'b0, 16'h2222, 16'h3333, 1, 0, 1, 1, 16'h0200, 16'h0AAA, 16'h0000, 0, 0, 1, 0, 1, 16'h2222, 16'h3333, 0};
    vecs[8] = '{1'b0, 16'h2222, 16'h3333, 1, 1, 1, 1, 16'h0200, 16'h0AAA, 16'h0000, 1, 0, 0, 1, 1, 16'h0200, 16'h0AAA, 0};

    drive(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].ca, vecs[i].cd, vecs[i].cw, vecs[i].co,
            vecs[i].dv, vecs[i].dw, vecs[i].da, vecs[i].dd, vecs[i].md);
      #1;
      chk($sformatf("v%0d_ready", i), bus.dev_ready, vecs[i].e_ready);
      chk($sformatf("v%0d_hold", i), bus.cpu_hold, vecs[i].e_hold);
      chk($sformatf("v%0d_wren_n", i), bus.mem_wren_n, vecs[i].e_wren);
      chk($sformatf("v%0d_oen_n", i), bus.mem_oen_n, vecs[i].e_oen);
      chk($sformatf("v%0d_rvalid", i), bus.dev_rvalid, vecs[i].e_rvalid);
      if (vecs[i].chk_bus) begin
        chk($sformatf("v%0d_addr", i), bus.mem_address, vecs[i].e_addr);
        chk($sformatf("v%0d_wdata", i), bus.mem_data_out, vecs[i].e_data);
      end
      if (vecs[i].e_rvalid) chk($sformatf("v%0d_rdata", i), bus.dev_rdata, vecs[i].md);
      $display("vector %0d: ready=%b hold=%b wren_n=%b oen_n=%b addr=%h rvalid=%b",
               i, bus.dev_ready, bus.cpu_hold, bus.mem_wren_n, bus.mem_oen_n,
               bus.mem_address, bus.dev_rvalid);
      tick();
    end

    // Continuous CPU reads with a secondary read waiting.
    drive(1, 16'h3000, 0, 1, 0, 1, 0, 16'h0ABC, 0, 16'h7777);
    tick();
    rst = 1'b0;
`ifdef MEM_ARB_STARVE_EN
    run_until_grant(d1, g1);
    chk("starve_granted", 16'(g1), 16'd1);
    chk("starve_denies", 16'(d1), 16'(LIMIT));
    chk("starve_hold", bus.cpu_hold, 1'b1);
    chk("starve_addr", bus.mem_address, 16'h0ABC);
    chk("starve_oen_n", bus.mem_oen_n, 1'b0);
    $display("starvation: %0d denies then grant hold=%b addr=%h", d1, bus.cpu_hold, bus.mem_address);
    tick();
    bus.dev_address = 16'h0DEF;
    #1;
    chk("after_hold_hold", bus.cpu_hold, 1'b0);
    chk("after_hold_ready", bus.dev_ready, 1'b0);
    chk("after_hold_rvalid", bus.dev_rvalid, 1'b1);
    chk("after_hold_rdata", bus.dev_rdata, 16'h7777);
    tick();
    run_until_grant(d2, g2);
    chk("restart_granted", 16'(g2), 16'd1);
    chk("restart_denies", 16'(d2 + 1), 16'(LIMIT));
    $display("restart: %0d denies before second forced slot", d2 + 1);
    tick();
    for (int k = 0; k < LIMIT; k++) begin
      #1;
      chk($sformatf("deny%0d_ready", k), bus.dev_ready, 1'b0);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("rst_in_hold_hold", bus.cpu_hold, 1'b0);
    chk("rst_in_hold_ready", bus.dev_ready, 1'b0);
    chk("rst_in_hold_oen_n", bus.mem_oen_n, 1'b1);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_hold", bus.cpu_hold, 1'b0);
    chk("post_rst_ready", bus.dev_ready, 1'b0);
    chk("post_rst_oen_n", bus.mem_oen_n, 1'b0);
    chk("post_rst_rvalid", bus.dev_rvalid, 1'b0);
    $display("reset in HOLD: hold=%b ready=%b rvalid=%b", bus.cpu_hold, bus.dev_ready, bus.dev_rvalid);
    tick();
`else
    grants = 0;
    holds = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      grants += int'(bus.dev_ready);
      holds  += int'(bus.cpu_hold);
      tick();
    end
    chk("nostarve_grants", 16'(grants), 16'd0);
    chk("nostarve_holds", 16'(holds), 16'd0);
    $display("no starvation logic: %0d grants, %0d holds in 20 busy cycles", grants, holds);
`endif

    pend = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      rst = (c == 0) || ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 3))
        0:       begin bus.cpu_wren_n = 1'b1; bus.cpu_oen_n = 1'b1; end
        3:       begin bus.cpu_wren_n = 1'b0; bus.cpu_oen_n = 1'b1; end
        default: begin bus.cpu_wren_n = 1'b1; bus.cpu_oen_n = 1'b0; end
      endcase
      bus.cpu_address  = 16'($urandom);
      bus.cpu_data_out = 16'($urandom);
      if (!pend && $urandom_range(0, 2) != 0) begin
        pend = 1'b1;
        bus.dev_we      = 1'($urandom);
        bus.dev_address = 16'($urandom);
        bus.dev_wdata   = 16'($urandom);
      end
      bus.dev_valid   = pend;
      bus.mem_data_in = 16'($urandom);
      #1;
      model_eval();
      chk($sformatf("r%0d_ready", c), bus.dev_ready, e_ready);
      chk($sformatf("r%0d_hold", c), bus.cpu_hold, e_hold);
      chk($sformatf("r%0d_wren_n", c), bus.mem_wren_n, e_wren);
      chk($sformatf("r%0d_oen_n", c), bus.mem_oen_n, e_oen);
      chk($sformatf("r%0d_addr", c), bus.mem_address, e_addr);
      chk($sformatf("r%0d_wdata", c), bus.mem_data_out, e_data);
      chk($sformatf("r%0d_rvalid", c), bus.dev_rvalid, m_rvalid);
      chk($sformatf("r%0d_rdata", c), bus.dev_rdata, bus.mem_data_in);
      chk($sformatf("r%0d_cpu_din", c), bus.cpu_data_in, bus.mem_data_in);
      chk($sformatf("r%0d_excl", c), bus.mem_wren_n || bus.mem_oen_n, 1'b1);
      chk($sformatf("r%0d_conflict", c),
          bus.dev_ready && (!bus.cpu_wren_n || !bus.cpu_oen_n) && !bus.cpu_hold, 1'b0);
      if (c % 100 == 0)
        $display("random %0d: rst=%b valid=%b ready=%b hold=%b wren_n=%b oen_n=%b",
                 c, rst, bus.dev_valid, bus.dev_ready, bus.cpu_hold, bus.mem_wren_n, bus.mem_oen_n);
      model_advance();
      if (e_ready) pend = 1'b0;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single 16-bit SRAM bus between the sequential CPU and one secondary bus master (DMA/video/debug) with a valid/ready port. The CPU's bus signals pass straight through whenever it drives the bus. The secondary master is granted only in cycles where the CPU leaves the bus idle (both strobes high), or in a forced slot after a starvation limit. It sits between the CPU's address/data/strobe pins and the memory pins.

## Interface
- STARVE_LIMIT, 8: consecutive denied secondary-request cycles before a forced slot (range 2..15).
- clk  in  1  system clock; everything samples on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_address  in  16  CPU bus address.
- cpu_data_out  in  16  CPU write data.
- cpu_wren_n  in  1  CPU write strobe, active-low.
- cpu_oen_n  in  1  CPU read strobe, active-low.
- cpu_data_in  out  16  read data to CPU; always equals mem_data_in.
- cpu_hold  out  1  CPU clock-enable inhibit; CPU must not advance state when 1.
- dev_valid  in  1  secondary request valid; held with fields stable until accepted.
- dev_we  in  1  1 = write, 0 = read.
- dev_address  in  16  secondary address.
- dev_wdata  in  16  secondary write data.
- dev_ready  out  1  request accepted this cycle (combinational).
- dev_rvalid  out  1  read data valid on dev_rdata (registered flag).
- dev_rdata  out  16  equals mem_data_in.
- mem_address  out  16  memory address.
- mem_data_out  out  16  memory write data.
- mem_wren_n  out  1  memory write strobe, active-low.
- mem_oen_n  out  1  memory read strobe, active-low.
- mem_data_in  in  16  memory read data, valid the cycle after mem_oen_n low.

## Operation
- cpu_busy = !cpu_wren_n || !cpu_oen_n.
- Two states: ARB and HOLD. Reset: ARB.
- ARB, cpu_busy: mem_* = cpu_* (combinational), dev_ready = 0.
- ARB, !cpu_busy, dev_valid: dev_ready = 1. mem_address = dev_address and mem_data_out = dev_wdata. dev_we=1 drives mem_wren_n=0, mem_oen_n=1; dev_we=0 drives mem_oen_n=0, mem_wren_n=1.
- ARB, idle, no dev_valid: mem strobes high; mem_address = cpu_address.
- HOLD: cpu_hold = 1; CPU strobes ignored; dev granted unconditionally as above (dev_valid is 1 on entry by construction). The next state is always ARB.
- dev_rvalid <= 1 in the cycle after a read accept, else 0.
- Invariant: mem_wren_n || mem_oen_n in every cycle, including reset.

## Timing
- Reset values (rst high): mem_wren_n = 1, mem_oen_n = 1, dev_ready = 0, cpu_hold = 0. Registered dev_rvalid = 0, starve_cnt = 0, state = ARB. The CPU is not passed through during reset.
- CPU path: zero latency, purely combinational.
- Secondary read: accept in cycle N; dev_rvalid = 1 and dev_rdata = data in cycle N+1. Secondary write completes in the accept cycle.
- starve_cnt (4 bits): increments on dev_valid && !dev_ready. It clears on dev_ready or !dev_valid and saturates at STARVE_LIMIT.
- A forced slot is taken when starve_cnt == STARVE_LIMIT-1 and another deny occurs. The next state is HOLD, and starve_cnt clears on the HOLD grant.
- Back-to-back HOLD slots are impossible; a minimum of STARVE_LIMIT deny cycles separates them.
- If dev_valid drops mid-wait, the counter clears and no HOLD is taken.
- If rst is asserted in HOLD, the block returns to ARB next cycle with cpu_hold = 0, and any pending dev_rvalid is cancelled.

## Configuration
- MEM_ARB_STARVE_EN: when defined, the starvation counter and HOLD state are compiled in as above.
- When undefined, HOLD, starve_cnt and STARVE_LIMIT are unused and cpu_hold is tied to 0. The secondary master is served only in CPU-idle cycles.

## Test plan
- Reset: hold rst high 2 cycles with cpu_oen_n = 0 and dev_valid = 1 -> strobes high, dev_ready = 0, cpu_hold = 0, dev_rvalid = 0.
- CPU pass-through: cpu_address = 0x1234, cpu_data_out = 0xBEEF, cpu_wren_n = 0 with dev_valid = 1 -> mem_address = 0x1234, mem_data_out = 0xBEEF, mem_wren_n = 0, dev_ready = 0 in the same cycle.
- Idle-slot read: CPU strobes high, dev read at 0x0040, memory returns 0x5A5A -> dev_ready = 1 in cycle N, mem_oen_n = 0; dev_rvalid = 1 and dev_rdata = 0x5A5A in N+1.
- Idle-slot write: dev_we = 1, dev_address = 0x0100, dev_wdata = 0x00FF, CPU idle -> mem_wren_n = 0 and mem_address = 0x0100 in the same cycle, dev_rvalid stays 0.
- Starvation (MEM_ARB_STARVE_EN, STARVE_LIMIT = 8): CPU reads continuously with dev_valid = 1 -> exactly 8 denied cycles. The 9th cycle has cpu_hold = 1, dev_ready = 1 and mem_address = dev_address; the next cycle has cpu_hold = 0 and counting restarts.
- Mutual exclusion: 1000 random cycles with random CPU/dev stimulus, honouring the CPU's own strobe exclusivity -> mem_wren_n || mem_oen_n every cycle. dev_ready never coincides with a CPU access outside HOLD.
